// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types for the v1.12 machine-mode privilege block.
package machine_mode_types_1_12_pkg;

    localparam int unsigned MCSR_ADDR_W = 12;
    localparam int unsigned WORD_W      = 32;

    typedef logic [MCSR_ADDR_W-1:0] mcsr_addr_t;
    typedef logic [WORD_W-1:0]      word_t;

    typedef enum logic [1:0] {
        PRIV_U    = 2'b00,
        PRIV_S    = 2'b01,
        PRIV_RSVD = 2'b10,
        PRIV_M    = 2'b11
    } priv_level_t;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_acc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } csr_acc_state_t;

    // A write-type access to a read-only CSR (addr[11:10]==2'b11) is illegal, as is any
    // access above the current privilege or to an unimplemented address.
    function automatic logic csr_access_illegal(
        input mcsr_addr_t  addr,
        input priv_level_t priv,
        input logic        wr_intent,
        input logic        invalid
    );
        return invalid
            | (addr[9:8] > 2'(priv))
            | (wr_intent & (addr[11:10] == 2'b11));
    endfunction

endpackage

// File: rtl/priv_1_12_csr_rr_arbiter.sv
// Two-way requester arbiter: round-robin (RR_ARB=1) or fixed priority to req 0 (RR_ARB=0).
module priv_1_12_csr_rr_arbiter #(
    parameter bit RR_ARB = 1'b1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Requester that won most recently; resets to 1 so req 0 wins the first tie.
    logic rr_last;

    // Winner selection.
    always_comb begin
        grant = 2'b00;
        if (RR_ARB) begin
            if (req == 2'b11) begin
                grant = rr_last ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end else begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end
    end

    // Remember the winner whenever a grant is consumed.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            rr_last <= grant[1];
        end
    end

endmodule

// File: rtl/priv_1_12_csr_access_ctrl.sv
// Shares the privilege-block CSR file port between the pipeline (req 0) and the
// debug/trap-service agent (req 1): arbitrate, check permission, strobe once, respond.
module priv_1_12_csr_access_ctrl
    import machine_mode_types_1_12_pkg::*;
#(
    parameter bit          RR_ARB = 1'b1,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             req,
    input  logic [1:0][1:0]        req_op,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             done,
    output logic [1:0][DATA_W-1:0] rdata,
    output logic [1:0]             err,
    input  priv_level_t            curr_priv,
    output logic [ADDR_W-1:0]      csr_addr,
    output logic                   csr_write,
    output logic                   csr_set,
    output logic                   csr_clear,
    output logic [DATA_W-1:0]      new_csr_val,
    input  logic [DATA_W-1:0]      old_csr_val,
    input  logic                   invalid_csr
);

    csr_acc_state_t state_q;
    csr_acc_state_t state_d;
    logic [1:0]     grant;
    logic           advance;
    logic           id_q;
    csr_acc_op_t    op_q;
    logic           wr_intent;
    logic           illegal;

    priv_1_12_csr_rr_arbiter #(
        .RR_ARB (RR_ARB)
    ) u_arb (
        .CLK     (CLK),
        .nRST    (nRST),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one transaction in flight, IDLE -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    advance = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Latch the winner; csr_addr/new_csr_val double as the address/data latch and are
    // only non-zero for the ACCESS cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            id_q        <= 1'b0;
            op_q        <= CSR_READ;
            csr_addr    <= '0;
            new_csr_val <= '0;
        end else if (advance) begin
            id_q        <= grant[1];
            op_q        <= csr_acc_op_t'(req_op[grant[1]]);
            csr_addr    <= req_addr[grant[1]];
            new_csr_val <= req_wdata[grant[1]];
        end else if (state_q == ST_ACCESS) begin
            csr_addr    <= '0;
            new_csr_val <= '0;
        end
    end

    // Permission check and strobe decode; strobes follow invalid_csr within the ACCESS
    // cycle, and an async reset clears state_q so they drop immediately.
    always_comb begin
        csr_write = 1'b0;
        csr_set   = 1'b0;
        csr_clear = 1'b0;
        wr_intent = (op_q == CSR_WRITE)
                  | (((op_q == CSR_SET) | (op_q == CSR_CLEAR)) & (new_csr_val != '0));
        illegal   = csr_access_illegal(mcsr_addr_t'(csr_addr), curr_priv, wr_intent,
                                       invalid_csr);
        if ((state_q == ST_ACCESS) && wr_intent && !illegal) begin
            unique case (op_q)
                CSR_WRITE: csr_write = 1'b1;
                CSR_SET:   csr_set   = 1'b1;
                CSR_CLEAR: csr_clear = 1'b1;
                default:   ;
            endcase
        end
    end

    // Response registers: one-cycle done with old value (zeroed on error) during RESP.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            done  <= '0;
            err   <= '0;
            rdata <= '0;
        end else begin
            done  <= '0;
            err   <= '0;
            rdata <= '0;
            if (state_q == ST_ACCESS) begin
                done[id_q]  <= 1'b1;
                err[id_q]   <= illegal;
                rdata[id_q] <= illegal ? '0 : old_csr_val;
            end
        end
    end

endmodule

// File: tb/tb_priv_1_12_csr_access_ctrl.sv
// Directed scoreboard bench for the CSR access controller (RR instance plus a fixed-priority twin).
module tb_priv_1_12_csr_access_ctrl;
    import machine_mode_types_1_12_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [1:0]          req;
    logic [1:0][1:0]     req_op;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][DW-1:0]  req_wdata;
    logic [1:0]          done;
    logic [1:0][DW-1:0]  rdata;
    logic [1:0]          err;
    priv_level_t         curr_priv;
    logic [AW-1:0]       csr_addr;
    logic                csr_write, csr_set, csr_clear;
    logic [DW-1:0]       new_csr_val;
    logic [DW-1:0]       old_csr_val;
    logic                invalid_csr;

    logic [1:0]          done_b;
    logic [1:0][DW-1:0]  rdata_b;
    logic [1:0]          err_b;
    logic [AW-1:0]       csr_addr_b;
    logic                wr_b, set_b, clr_b;
    logic [DW-1:0]       ncv_b;

    // CSR file environment (written only through DUT strobes) and independent reference.
    logic [DW-1:0] csr_mem [4096];
    logic [DW-1:0] ref_mem [4096];
    logic          inv_force;

    assign old_csr_val = csr_mem[csr_addr];
    assign invalid_csr = inv_force;

    always #5 CLK = ~CLK;

    priv_1_12_csr_access_ctrl #(.RR_ARB(1'b1), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err), .curr_priv(curr_priv),
        .csr_addr(csr_addr), .csr_write(csr_write), .csr_set(csr_set), .csr_clear(csr_clear),
        .new_csr_val(new_csr_val), .old_csr_val(old_csr_val), .invalid_csr(invalid_csr)
    );

    priv_1_12_csr_access_ctrl #(.RR_ARB(1'b0), .ADDR_W(AW), .DATA_W(DW)) dut_fixed (
        .CLK(CLK), .nRST(nRST), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done_b), .rdata(rdata_b), .err(err_b), .curr_priv(curr_priv),
        .csr_addr(csr_addr_b), .csr_write(wr_b), .csr_set(set_b), .csr_clear(clr_b),
        .new_csr_val(ncv_b), .old_csr_val(32'h0), .invalid_csr(1'b0)
    );

    typedef struct {
        logic [1:0]    done;
        logic [DW-1:0] rdata;
        logic          err;
        logic [1:0]    strb;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            ref_cyc = 0;
    int            strb_cnt = 0;
    logic [1:0]    strb_seen = 2'd0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_v;
    logic [1:0]    pend_op;
    bit   [1:0]    hold = 2'b00;
    bit            chk_b = 1'b0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {16'hC0DE, 4'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply last cycle's strobe to the CSR file, observe strobes and responses.
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (pend) begin
            case (pend_op)
                2'd1:    csr_mem[pend_a] = pend_v;
                2'd2:    csr_mem[pend_a] = csr_mem[pend_a] | pend_v;
                default: csr_mem[pend_a] = csr_mem[pend_a] & ~pend_v;
            endcase
            pend = 1'b0;
        end
        if (csr_write || csr_set || csr_clear) begin
            strb_cnt  = strb_cnt + int'(csr_write) + int'(csr_set) + int'(csr_clear);
            strb_seen = csr_write ? 2'd1 : (csr_set ? 2'd2 : 2'd3);
            pend      = 1'b1;
            pend_a    = csr_addr;
            pend_v    = new_csr_val;
            pend_op   = strb_seen;
        end
        if (done !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("done", 64'(done), 64'(e.done));
                chk("rdata", 64'(rdata[e.done[1]]), 64'(e.rdata));
                chk("err", 64'(err), 64'(e.err ? e.done : 2'b00));
                chk("strobe_kind", 64'(strb_seen), 64'(e.strb));
                chk("strobe_cycles", 64'(strb_cnt), 64'(e.strb != 2'd0 ? 1 : 0));
                chk("latency", 64'(cyc - ref_cyc), 64'(e.lat));
                chk("csr_addr_idle", 64'(csr_addr), 64'(0));
                if (chk_b) chk("fixed_prio_done", 64'(done_b), 64'(2'b01));
            end
            ref_cyc   = cyc;
            strb_cnt  = 0;
            strb_seen = 2'd0;
            for (int i = 0; i < 2; i++) begin
                if (done[i] && !hold[i]) req[i] = 1'b0;
            end
        end
    endtask

    // Build the expectation from the access rules and update the reference CSR image.
    task automatic expect_xact(input bit id, input logic [1:0] op, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input int lat);
        exp_t e;
        logic wi;
        logic ill;
        wi  = (op == 2'd1) || (((op == 2'd2) || (op == 2'd3)) && (wd != '0));
        ill = inv_force || (a[9:8] > 2'(curr_priv)) || (wi && (a[11:10] == 2'b11));
        e.done  = id ? 2'b10 : 2'b01;
        e.err   = ill;
        e.rdata = ill ? '0 : ref_mem[a];
        e.strb  = (wi && !ill) ? op : 2'd0;
        e.lat   = lat;
        if (wi && !ill) begin
            case (op)
                2'd1:    ref_mem[a] = wd;
                2'd2:    ref_mem[a] = ref_mem[a] | wd;
                default: ref_mem[a] = ref_mem[a] & ~wd;
            endcase
        end
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < budget)) begin
            tick();
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        tick();
    endtask

    task automatic issue(input bit id, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit drop_early);
        expect_xact(id, op, a, wd, 2);
        req_op[id]    = op;
        req_addr[id]  = a;
        req_wdata[id] = wd;
        req[id]       = 1'b1;
        ref_cyc       = cyc;
        if (drop_early) begin
            tick();
            req[id] = 1'b0;
        end
        drain(10);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = init_val(AW'(i));
            ref_mem[i] = init_val(AW'(i));
        end
        nRST      = 1'b0;
        req       = '0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        curr_priv = PRIV_M;
        inv_force = 1'b0;
        tick();
        tick();
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_strobes", 64'({csr_write, csr_set, csr_clear}), 64'(0));
        chk("rst_csr_addr", 64'(csr_addr), 64'(0));
        chk("rst_new_csr_val", 64'(new_csr_val), 64'(0));
        nRST = 1'b1;
        tick();

        // Write then read back.
        issue(1'b0, 2'd1, 12'h340, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'd0, 12'h340, 32'h0, 1'b0);

        // Read-only CSR: zero-mask SET is a read, non-zero mask is illegal.
        issue(1'b1, 2'd2, 12'hF11, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 12'hF11, 32'h1, 1'b0);

        // SET/CLEAR on a writable CSR, each followed by a read-back.
        issue(1'b1, 2'd2, 12'h300, 32'h0000_0088, 1'b0);
        issue(1'b0, 2'd0, 12'h300, 32'h0, 1'b0);
        issue(1'b0, 2'd3, 12'h300, 32'h0000_0008, 1'b0);
        issue(1'b1, 2'd0, 12'h300, 32'h0, 1'b0);

        // Privilege checks.
        curr_priv = PRIV_U;
        issue(1'b0, 2'd0, 12'h300, 32'h0, 1'b0);
        curr_priv = PRIV_S;
        issue(1'b0, 2'd1, 12'h140, 32'h5555_AAAA, 1'b0);
        issue(1'b0, 2'd1, 12'h340, 32'h1111_1111, 1'b0);
        issue(1'b1, 2'd0, 12'h140, 32'h0, 1'b0);
        curr_priv = PRIV_M;

        // Unimplemented address: error, no strobe, value untouched.
        inv_force = 1'b1;
        issue(1'b0, 2'd0, 12'h305, 32'h0, 1'b0);
        issue(1'b1, 2'd1, 12'h305, 32'hFFFF_0000, 1'b0);
        inv_force = 1'b0;
        issue(1'b1, 2'd0, 12'h305, 32'h0, 1'b0);

        // Requester withdraws after sampling; transaction still completes.
        issue(1'b1, 2'd1, 12'h341, 32'h0BAD_F00D, 1'b1);

        // Reset during the ACCESS cycle of a write.
        req_op[0]    = 2'd1;
        req_addr[0]  = 12'h340;
        req_wdata[0] = 32'h1234_5678;
        req[0]       = 1'b1;
        tick();
        chk("write_strobe_before_rst", 64'(csr_write), 64'(1));
        #2;
        nRST = 1'b0;
        #1;
        chk("write_strobe_async_kill", 64'(csr_write), 64'(0));
        chk("csr_addr_async_kill", 64'(csr_addr), 64'(0));
        pend      = 1'b0;
        strb_cnt  = 0;
        strb_seen = 2'd0;
        tick();
        tick();
        chk("no_done_in_rst", 64'(done), 64'(0));
        nRST = 1'b1;
        expect_xact(1'b0, 2'd1, 12'h340, 32'h1234_5678, 2);
        ref_cyc = cyc;
        drain(10);
        issue(1'b0, 2'd0, 12'h340, 32'h0, 1'b0);

        // Both requesters held: RR alternates 1,0,1,0 after a req0 win; fixed twin always 0.
        issue(1'b0, 2'd0, 12'h301, 32'h0, 1'b0);
        chk_b        = 1'b1;
        hold         = 2'b11;
        req_op       = '0;
        req_addr[0]  = 12'h342;
        req_addr[1]  = 12'h341;
        expect_xact(1'b1, 2'd0, 12'h341, 32'h0, 2);
        expect_xact(1'b0, 2'd0, 12'h342, 32'h0, 3);
        expect_xact(1'b1, 2'd0, 12'h341, 32'h0, 3);
        expect_xact(1'b0, 2'd0, 12'h342, 32'h0, 3);
        req     = 2'b11;
        ref_cyc = cyc;
        for (int n = 0; (n < 40) && (sb.size() != 0); n++) begin
            tick();
        end
        req   = 2'b00;
        hold  = 2'b00;
        chk_b = 1'b0;
        chk("held_drain", 64'(sb.size()), 64'(0));
        tick();
        tick();
        tick();
        chk("quiet_after_held", 64'({done, done_b}), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
